// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Signed (DIV) and unsigned (DIVU) modes, start/busy/done handshake,
// divide-by-zero flag. Quotient feeds LO, remainder feeds HI.
// Optional build macro DIV_EARLY_EXIT_EN: skip the shift/subtract loop
// when |dividend| < |divisor|.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0]   quo, quo_nxt;
    logic [WIDTH-1:0]   dvs, dvs_nxt;
    logic               sgn, sgn_nxt;
    logic               neg_a, neg_a_nxt;
    logic               neg_b, neg_b_nxt;
    logic               busy_nxt, done_nxt, div_zero_nxt;
    logic [WIDTH-1:0]   quotient_nxt, remainder_nxt;

    logic               in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH+1:0]   trial;

    // Operand magnitudes at the inputs; ~x+1 is exact for MIN read as unsigned
    always_comb begin
        in_neg_a = is_signed & dividend[WIDTH-1];
        in_neg_b = is_signed & divisor[WIDTH-1];
        mag_a    = in_neg_a ? (~dividend + WIDTH'(1)) : dividend;
        mag_b    = in_neg_b ? (~divisor + WIDTH'(1)) : divisor;
    end

    // Trial subtraction of the shifted partial remainder; MSB set means negative
    always_comb begin
        trial = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvs};
    end

    // Next-state and datapath/output next values
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rem_nxt       = rem;
        quo_nxt       = quo;
        dvs_nxt       = dvs;
        sgn_nxt       = sgn;
        neg_a_nxt     = neg_a;
        neg_b_nxt     = neg_b;
        div_zero_nxt  = div_zero;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;

        case (state)
            IDLE: begin
                if (start) begin
                    sgn_nxt   = is_signed;
                    neg_a_nxt = in_neg_a;
                    neg_b_nxt = in_neg_b;
                    dvs_nxt   = mag_b;
                    rem_nxt   = '0;
                    quo_nxt   = mag_a;
                    cnt_nxt   = CNT_W'(WIDTH);
                    if (divisor == '0) begin
                        div_zero_nxt  = 1'b1;
                        quotient_nxt  = '0;
                        remainder_nxt = '0;
                        state_nxt     = DONE;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (mag_a < mag_b) begin
                        div_zero_nxt = 1'b0;
                        quo_nxt      = '0;
                        rem_nxt      = mag_a;
                        state_nxt    = FIXUP;
                    end
`endif
                    else begin
                        div_zero_nxt = 1'b0;
                        state_nxt    = CALC;
                    end
                end
            end
            CALC: begin
                rem_nxt = trial[WIDTH+1] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : WIDTH'(trial);
                quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP: begin
                quotient_nxt  = (sgn & (neg_a ^ neg_b)) ? (~quo + WIDTH'(1)) : quo;
                remainder_nxt = (sgn & neg_a) ? (~rem + WIDTH'(1)) : rem;
                state_nxt     = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == CALC) || (state_nxt == FIXUP);
        done_nxt = (state_nxt == DONE);
    end

    // State, datapath and registered outputs; reset aborts any operation
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            sgn       <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rem       <= rem_nxt;
            quo       <= quo_nxt;
            dvs       <= dvs_nxt;
            sgn       <= sgn_nxt;
            neg_a     <= neg_a_nxt;
            neg_b     <= neg_b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            div_zero  <= div_zero_nxt;
            quotient  <= quotient_nxt;
            remainder <= remainder_nxt;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq (WIDTH=32). Honours DIV_EARLY_EXIT_EN.
module tb_div_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_zero;
    logic [31:0] quotient, remainder;

    div_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_zero(div_zero), .quotient(quotient), .remainder(remainder)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          busy_n;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain arithmetic, truncating signed division, remainder follows dividend
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b, output exp_t e);
        int          sa, sb_i;
        logic [31:0] ma, mb;
        sa = a;
        sb_i = b;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        e.dz = (b == 0);
        if (b == 0) begin
            e.q = 0; e.r = 0; e.lat = 1; e.busy_n = 0;
        end else begin
            if (!sgn) begin
                e.q = a / b; e.r = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000; e.r = 0;
            end else begin
                e.q = 32'(sa / sb_i); e.r = 32'(sa % sb_i);
            end
            e.lat = 34; e.busy_n = 33;
`ifdef DIV_EARLY_EXIT_EN
            if (ma < mb) begin
                e.lat = 2; e.busy_n = 1;
            end
`else
            if (ma == 0 && mb == 0) e.lat = 34;
`endif
        end
    endtask

    // Monitor: pop and compare whenever the DUT reports done
    always @(negedge clock) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_zero", 32'(div_zero), 32'(e.dz));
                    check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.busy_n));
                end
                busy_cnt = 0;
            end
        end
    end

    // Issue one operation, disturb inputs while it runs, wait for done (bounded)
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit noisy);
        exp_t e;
        bit   seen;
        model(sgn, a, b, e);
        e.start_cyc = cyc;
        sb.push_back(e);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (noisy) begin
                dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
                start = busy && ($urandom_range(0, 5) == 0);
            end
            @(negedge clock);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
            sb.delete();
        end
        last_q = e.q; last_r = e.r;
        // start during the DONE cycle must be ignored
        start = 1'b1; dividend = 32'd50; divisor = 32'd3;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;

        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        check("reset_q", quotient, 32'd0);
        check("reset_r", remainder, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_op(1, 32'd7, 32'd2, 1);
        do_op(1, -32'd7, 32'd2, 0);
        do_op(1, 32'd7, -32'd2, 1);
        do_op(1, -32'd7, -32'd2, 0);
        do_op(0, 32'hFFFF_FFFF, 32'd2, 1);
        do_op(1, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_op(0, 32'h8000_0000, 32'h10, 0);
        do_op(0, 32'd100, 32'd0, 1);
        do_op(0, 32'd100, 32'd7, 0);
        do_op(1, 32'd100, 32'd0, 0);
        do_op(1, 32'd100, 32'd7, 1);
        do_op(0, 32'd3, 32'd10, 0);
        do_op(1, -32'd3, 32'd10, 1);

        // Results hold while idle
        repeat (4) @(negedge clock);
        check("hold_q", quotient, last_q);
        check("hold_r", remainder, last_r);

        // Reset ten cycles into an operation: abort, no done pulse
        is_signed = 1'b1; dividend = 32'd1234; divisor = 32'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_dz", 32'(div_zero), 32'd0);
        repeat (40) @(negedge clock);

        // Randomized operations with boundary-heavy operand choice
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin b = $urandom; a = $urandom_range(0, 20); end
                default: b = $urandom;
            endcase
            do_op(s, a, b, 1'($urandom));
        end

        repeat (5) @(negedge clock);
        check("pending_ops", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
